dm_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (port 0) and a secondary master (port 1: program loader, debug or DMA). It selects one request per cycle, drives the memory's word address, byte enables and write data, and returns read data one cycle later. It also raises a stall to the pipeline whenever port 0 is refused. Port 0 has fixed priority, with an optional anti-starvation counter for port 1.

---
 rtl/dm_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares the single-ported data memory between the pipeline MEM stage
// (port 0) and a secondary master such as a loader, debug or DMA (port 1).
// One request is granted per cycle. The granted port drives the memory's
// word address, byte enables and write data. Read data comes back one cycle
// later as a full 32-bit word. Any lane select or sign extension is left to
// the requester.
//
// Port 0 has fixed priority. If DM_ARB_FAIR_EN is defined, a saturating
// wait counter is added. Once port 1 has been refused STARVE_MAX cycles in
// a row, it wins the next contended cycle. Without the macro the arbiter is
// strict priority and carries no counter state.
//
// Parameters
//   STARVE_MAX  refused cycles of port 1 before it is forced through (1..15)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   reqN/weN              request and write flag, port N
//   addrN/beN/wdataN      byte address (bits [15:2] used), byte enables, data
//   gntN                  combinational grant; the access happens this cycle
//   rvalidN/rdataN        registered read return, one cycle after the grant
//   stall0                port 0 requested but was refused this cycle
//   mem_*                 memory side: enable, write, byte enables, word
//                         index, write data, combinational read data
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [3:0]  be0,
    input  logic [31:0] wdata0,
    output logic        gnt0,
    output logic        rvalid0,
    output logic [31:0] rdata0,
    output logic        stall0,

    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [3:0]  be1,
    input  logic [31:0] wdata1,
    output logic        gnt1,
    output logic        rvalid1,
    output logic [31:0] rdata1,

    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("dm_port_arbiter: STARVE_MAX must be in 1..15");
    end

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
`ifdef DM_ARB_FAIR_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       starved;

    // Port 1 has been refused STARVE_MAX times, so it takes the next
    // contended cycle.
    assign starved = (wait_cnt_q == STARVE_MAX[3:0]);

    always_comb begin
        gnt0 = req0 & ~(req1 & starved);
        gnt1 = req1 & (~req0 | starved);
    end

    // Count consecutive refusals of port 1. The count clears as soon as
    // port 1 is served or stops asking, so the "consecutive" meaning holds.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1 || gnt1) begin
            wait_cnt_d = 4'd0;
        end else if (!starved) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        gnt0 = req0;
        gnt1 = req1 & ~req0;
    end
`endif

    assign stall0 = req0 & ~gnt0;

    // -----------------------------------------------------------------------
    // Memory-side mux
    // -----------------------------------------------------------------------
    // Port 1 fields are selected only when port 1 holds the grant. In every
    // other case, including idle, port 0 drives the bus. The address and
    // data are don't-care while mem_en is low.
    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = (gnt0 & we0) | (gnt1 & we1);
        mem_addr  = addr0[15:2];
        mem_be    = be0;
        mem_wdata = wdata0;
        if (gnt1) begin
            mem_addr  = addr1[15:2];
            mem_be    = be1;
            mem_wdata = wdata1;
        end
    end

    // Only the word index bits of the byte address reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:16], addr0[1:0], addr1[31:16], addr1[1:0]};

    // -----------------------------------------------------------------------
    // Read return
    // -----------------------------------------------------------------------
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q,  rdata0_d;
    logic [31:0] rdata1_q,  rdata1_d;

    // rvalid lasts exactly one cycle. rdata loads only on a granted read,
    // so it keeps the last returned word between reads.
    always_comb begin
        rvalid0_d = gnt0 & ~we0;
        rvalid1_d = gnt1 & ~we1;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    // Reset drops a read that is still in flight. A write granted in a
    // reset cycle still reaches the memory through the combinational bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  be0, be1;
    logic        gnt0, gnt1, rvalid0, rvalid1, stall0;
    logic [31:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .be0(be0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .stall0(stall0),
        .req1(req1), .we1(we1), .addr1(addr1), .be1(be1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Simple byte-writable memory model, combinational read.
    logic [31:0] mem [0:16383];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

`ifdef DM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; be0 = b; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; be1 = b; wdata1 = d;
    endtask

    task automatic idle();
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Check one contended cycle, with port 0 at word 0x40 and port 1 at 0x80.
    task automatic chk_cont(input string tag, input logic exp_g1);
        chk({tag, " gnt0"},  {31'd0, gnt0},   {31'd0, ~exp_g1});
        chk({tag, " gnt1"},  {31'd0, gnt1},   {31'd0, exp_g1});
        chk({tag, " stall0"}, {31'd0, stall0}, {31'd0, exp_g1});
        chk({tag, " addr"},  {18'd0, mem_addr}, exp_g1 ? 32'h80 : 32'h40);
    endtask

    logic prev_g1;
    logic exp_g1;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
        mem[14'h40] = 32'h1111_0000;
        mem[14'h80] = 32'h2222_0000;
        rst = 1'b1;
        idle();
        cyc();
        cyc();

        // Reset state
        #1;
        chk("rst rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst rdata0", rdata0, 32'd0);
        chk("rst rdata1", rdata1, 32'd0);
        chk("rst mem_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b0;
        cyc();

        // Port 0 write then read of the same word
        set0(1'b1, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        #1;
        chk("p0w gnt0", {31'd0, gnt0}, 32'd1);
        chk("p0w mem_addr", {18'd0, mem_addr}, 32'd4);
        chk("p0w mem_we", {31'd0, mem_we}, 32'd1);
        chk("p0w mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("p0w stall0", {31'd0, stall0}, 32'd0);
        cyc();
        set0(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        #1;
        chk("p0r mem_we", {31'd0, mem_we}, 32'd0);
        chk("p0r no wr rvalid", {31'd0, rvalid0}, 32'd0);
        cyc();
        idle();
        #1;
        chk("p0r rvalid0", {31'd0, rvalid0}, 32'd1);
        chk("p0r rdata0", rdata0, 32'hDEAD_BEEF);
        chk("idle mem_en", {31'd0, mem_en}, 32'd0);
        chk("idle gnt1", {31'd0, gnt1}, 32'd0);
        cyc();
        chk("p0r rvalid0 drop", {31'd0, rvalid0}, 32'd0);
        chk("p0r rdata0 hold", rdata0, 32'hDEAD_BEEF);

        // Port 1 byte-lane write, then read back the full word
        set1(1'b1, 1'b1, 32'h0000_0023, 4'b1000, 32'hAB00_0000);
        #1;
        chk("lane mem_addr", {18'd0, mem_addr}, 32'd8);
        chk("lane mem_be", {28'd0, mem_be}, 32'h8);
        chk("lane gnt1", {31'd0, gnt1}, 32'd1);
        chk("lane gnt0", {31'd0, gnt0}, 32'd0);
        chk("lane stall0", {31'd0, stall0}, 32'd0);
        chk("lane mem_we", {31'd0, mem_we}, 32'd1);
        chk("lane mem_wdata", mem_wdata, 32'hAB00_0000);
        cyc();
        set1(1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        cyc();
        idle();
        #1;
        chk("lane rvalid1", {31'd0, rvalid1}, 32'd1);
        chk("lane rdata1", rdata1, 32'hAB00_0000);
        chk("lane rvalid0", {31'd0, rvalid0}, 32'd0);

        // Back-to-back reads on port 0
        set0(1'b1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);
        cyc();
        set0(1'b1, 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        #1;
        chk("b2b rvalid0 a", {31'd0, rvalid0}, 32'd1);
        chk("b2b rdata0 a", rdata0, 32'hDEAD_BEEF);
        cyc();
        idle();
        #1;
        chk("b2b rvalid0 b", {31'd0, rvalid0}, 32'd1);
        chk("b2b rdata0 b", rdata0, 32'hAB00_0000);

        // Write with no byte enables is still a granted write
        set0(1'b1, 1'b1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF);
        #1;
        chk("be0 gnt0", {31'd0, gnt0}, 32'd1);
        chk("be0 mem_we", {31'd0, mem_we}, 32'd1);
        chk("be0 mem_en", {31'd0, mem_en}, 32'd1);
        chk("be0 mem_be", {28'd0, mem_be}, 32'd0);
        cyc();
        idle();
        cyc();

        // Sustained contention, both ports reading
        set0(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        set1(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        prev_g1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            exp_g1 = FAIR && (i % 5 == 4);
            #1;
            chk_cont($sformatf("cont%0d", i), exp_g1);
            cyc();
            chk($sformatf("cont%0d rvalid1", i), {31'd0, rvalid1}, {31'd0, exp_g1});
            if (exp_g1) chk($sformatf("cont%0d rdata1", i), rdata1, 32'h2222_0000);
            prev_g1 = exp_g1;
        end
        idle();
        cyc();

        // Counter clears when port 1 drops its request for one cycle
        set0(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        for (int i = 0; i < 10; i++) begin
            req1 = (i != 3);
            addr1 = 32'h0000_0200;
            we1 = 1'b0;
            exp_g1 = FAIR && (i == 8);
            #1;
            chk($sformatf("clr%0d gnt1", i), {31'd0, gnt1}, {31'd0, exp_g1});
            chk($sformatf("clr%0d gnt0", i), {31'd0, gnt0}, {31'd0, ~exp_g1});
            cyc();
        end
        idle();
        cyc();

        // Reset during contention returns the counter to 0
        set0(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        set1(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rstc gnt0", {31'd0, gnt0}, 32'd1);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_g1 = FAIR && (i == 4);
            #1;
            chk($sformatf("rstc%0d gnt1", i), {31'd0, gnt1}, {31'd0, exp_g1});
            cyc();
        end
        idle();
        cyc();

        // Reset in the cycle after a granted port 1 read
        set1(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        #1;
        chk("rmr gnt1", {31'd0, gnt1}, 32'd1);
        cyc();
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set0(1'b1, 1'b1, 32'h0000_0300, 4'hF, 32'h5A5A_5A5A);
        rst = 1'b1;
        #1;
        chk("rmr wr gnt0", {31'd0, gnt0}, 32'd1);
        chk("rmr wr mem_we", {31'd0, mem_we}, 32'd1);
        cyc();
        rst = 1'b0;
        idle();
        #1;
        chk("rmr rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rmr rdata1", rdata1, 32'd0);
        chk("rmr mem write", mem[14'hC0], 32'h5A5A_5A5A);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
